// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one synchronous memory port between two requesters. Requester 0 is
// the CPU data side and requester 1 is a loader/debug/DMA agent. The requests
// are granted round-robin. The winning transaction is latched and held on the
// memory port for MEM_LAT cycles. It then completes with a one-cycle ack to
// its owner. After each ack the arbiter spends one cycle in DONE before it
// arbitrates again.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  cycles the memory port is held per access (>= 1)
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   r0_req / r1_req     request, held until ack
//   r0_addr / r1_addr   access address
//   r0_wdata / r1_wdata write data
//   r0_sz / r1_sz       0 = 8-bit, 1 = 16-bit
//   r0_we / r1_we       1 = write, 0 = read
//   r0_ack / r1_ack     one-cycle completion pulse
//   r0_rdata / r1_rdata read result, valid with ack, held until the next ack
//   mem_addr/wdata/sz/we  memory port drive
//   mem_rdata           memory read data
//   busy                high while in ACCESS or DONE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_sz,
  input  logic              r0_we,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,

  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_sz,
  input  logic              r1_we,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_sz,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  // The counter holds values 0 .. MEM_LAT-1. It is kept at least one bit wide
  // so that a MEM_LAT=1 build still elaborates.
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic               r_last_grant;
  logic               r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic               w_grant_vld;
  logic               w_grant_id;
  logic               w_done;

  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_sel_sz;
  logic               w_sel_we;

  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_mem_sz;
  logic               r_mem_we;
  logic               r_r0_ack;
  logic               r_r1_ack;
  logic [DATA_W-1:0]  r_r0_rdata;
  logic [DATA_W-1:0]  r_r1_rdata;
  logic               r_busy;

  // ---------------------------------------------------------------------------
  // Next-state and arbitration
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so that no path leaves
  // one unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant_vld = 1'b0;
    w_grant_id  = r_last_grant;
    w_done      = 1'b0;

    unique case (r_state)
      IDLE: begin
        // On a tie the requester that did not win last time is granted.
        if (r0_req && r1_req) begin
          w_grant_vld = 1'b1;
          w_grant_id  = ~r_last_grant;
        end else if (r0_req) begin
          w_grant_vld = 1'b1;
          w_grant_id  = 1'b0;
        end else if (r1_req) begin
          w_grant_vld = 1'b1;
          w_grant_id  = 1'b1;
        end
        if (w_grant_vld) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = CNT_LOAD;
        end
      end

      ACCESS: begin
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end

      // Requests are not looked at in DONE. The requester that was just
      // acked can therefore drop or replace its request without being
      // granted again by mistake.
      DONE:    w_state_nxt = IDLE;

      default: w_state_nxt = IDLE;
    endcase
  end

  // The winner's fields are selected here and latched only at the grant edge.
  always_comb begin
    w_sel_addr  = w_grant_id ? r1_addr  : r0_addr;
    w_sel_wdata = w_grant_id ? r1_wdata : r0_wdata;
    w_sel_sz    = w_grant_id ? r1_sz    : r0_sz;
    w_sel_we    = w_grant_id ? r1_we    : r0_we;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments. All
  // registers then sample the values from before the edge, whatever order the
  // blocks run in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  // Reset clears mem_we at once, so a transaction that is under way when
  // reset arrives is abandoned and no ack is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_sz     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_r0_ack     <= 1'b0;
      r_r1_ack     <= 1'b0;
      r_r0_rdata   <= '0;
      r_r1_rdata   <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_busy   <= (w_state_nxt != IDLE);
      r_r0_ack <= w_done && !r_owner;
      r_r1_ack <= w_done &&  r_owner;

      if (w_grant_vld) begin
        r_last_grant <= w_grant_id;
        r_owner      <= w_grant_id;
        r_mem_addr   <= w_sel_addr;
        r_mem_wdata  <= w_sel_wdata;
        r_mem_sz     <= w_sel_sz;
        r_mem_we     <= w_sel_we;
      end

      if (w_done) begin
        r_mem_we <= 1'b0;
        // r_mem_we still holds the latched direction here. A completed write
        // leaves the owner's previous read data unchanged.
        if (!r_mem_we) begin
          if (r_owner) r_r1_rdata <= mem_rdata;
          else         r_r0_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_sz    = r_mem_sz;
  assign mem_we    = r_mem_we;
  assign r0_ack    = r_r0_ack;
  assign r1_ack    = r_r1_ack;
  assign r0_rdata  = r_r0_rdata;
  assign r1_rdata  = r_r1_rdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter.
// u_dut  : MEM_LAT=2, attached to a small byte-lane memory model.
// u_dut1 : MEM_LAT=1. Its memory returns (addr ^ 16'hA5A5).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;

  logic        r0_req, r1_req;
  logic [15:0] r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;
  logic        r0_sz, r1_sz;
  logic        r0_we, r1_we;
  logic        r0_ack, r1_ack;
  logic [15:0] r0_rdata, r1_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_sz, mem_we;
  logic        busy;

  logic        b_req;
  logic [15:0] b_addr;
  logic        b_r0_ack, b_r1_ack;
  logic [15:0] b_r0_rdata, b_r1_rdata;
  logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_mem_sz, b_mem_we;
  logic        b_busy;

  int n_checks;
  int n_pass;

  logic        mem_init;
  logic [15:0] mem [256];

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) u_dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_sz(r0_sz),
    .r0_we(r0_we), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_sz(r1_sz),
    .r1_we(r1_we), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sz(mem_sz),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .r0_req(b_req), .r0_addr(b_addr), .r0_wdata(16'h0000), .r0_sz(1'b1),
    .r0_we(1'b0), .r0_ack(b_r0_ack), .r0_rdata(b_r0_rdata),
    .r1_req(1'b0), .r1_addr(16'h0000), .r1_wdata(16'h0000), .r1_sz(1'b0),
    .r1_we(1'b0), .r1_ack(b_r1_ack), .r1_rdata(b_r1_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_sz(b_mem_sz),
    .mem_we(b_mem_we), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word array indexed by the low address byte. An 8-bit
  // access touches only the low byte, and an 8-bit read is zero-extended.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h04] <= 16'h1234;
      mem[8'hFC] <= 16'hCDEF;
    end else if (mem_we) begin
      if (mem_sz) mem[mem_addr[7:0]]      <= mem_wdata;
      else        mem[mem_addr[7:0]][7:0] <= mem_wdata[7:0];
    end
  end

  always_comb begin
    logic [15:0] w;
    w = mem[mem_addr[7:0]];
    mem_rdata = mem_sz ? w : {8'h00, w[7:0]};
  end

  assign b_mem_rdata = b_mem_addr ^ 16'hA5A5;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    mem_init = 1'b1;
    r0_req = 0; r0_addr = 0; r0_wdata = 0; r0_sz = 0; r0_we = 0;
    r1_req = 0; r1_addr = 0; r1_wdata = 0; r1_sz = 0; r1_we = 0;
    b_req  = 0; b_addr  = 0;

    // Reset state
    repeat (2) tick();
    check("rst_busy",     busy,     0);
    check("rst_mem_we",   mem_we,   0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_r0_ack",   r0_ack,   0);
    check("rst_r1_rdata", r1_rdata, 0);
    check("rst_b_busy",   b_busy,   0);
    mem_init = 1'b0;
    reset    = 1'b1;

    // Single 16-bit read by r0 at 0x0004
    r0_req = 1; r0_addr = 16'h0004; r0_sz = 1; r0_we = 0;
    tick();
    check("rd_busy",   busy,     1);
    check("rd_addr0",  mem_addr, 16'h0004);
    check("rd_we0",    mem_we,   0);
    check("rd_ack_e0", r0_ack,   0);
    tick();
    check("rd_addr1",  mem_addr, 16'h0004);
    check("rd_ack_e1", r0_ack,   0);
    tick();
    check("rd_ack",    r0_ack,   1);
    check("rd_data",   r0_rdata, 16'h1234);
    check("rd_r1_ack", r1_ack,   0);
    r0_req = 0;
    tick();
    check("rd_ack_off", r0_ack, 0);
    check("rd_idle",    busy,   0);

    // 8-bit write by r1 to 0x7FFC, then an 8-bit readback
    r1_req = 1; r1_addr = 16'h7FFC; r1_wdata = 16'h00AB; r1_sz = 0; r1_we = 1;
    tick();
    check("wr_we0",  mem_we, 1);
    check("wr_sz",   mem_sz, 0);
    tick();
    check("wr_we1",  mem_we, 1);
    tick();
    check("wr_we2",  mem_we, 0);
    check("wr_ack",  r1_ack, 1);
    check("wr_rdata_kept", r1_rdata, 0);
    r1_req = 0;
    tick();
    r1_req = 1; r1_we = 0; r1_wdata = 16'h0000;
    repeat (3) tick();
    check("rb_ack",  r1_ack,   1);
    check("rb_data", r1_rdata, 16'h00AB);
    r1_req = 0;
    tick();

    // Contention from reset: grants must go r0, r1, r0, r1
    reset = 1'b0;
    #2 reset = 1'b1;
    r0_req = 1; r0_addr = 16'h0004; r0_sz = 1; r0_we = 0;
    r1_req = 1; r1_addr = 16'h7FFC; r1_sz = 0; r1_we = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("ct_r0_ack_%0d", i), r0_ack, (i == 3 || i == 11));
      check($sformatf("ct_r1_ack_%0d", i), r1_ack, (i == 7 || i == 15));
      if (i == 1 || i == 9)
        check($sformatf("ct_addr_%0d", i), mem_addr, 16'h0004);
      if (i == 5 || i == 13)
        check($sformatf("ct_addr_%0d", i), mem_addr, 16'h7FFC);
      if (i == 4 || i == 8)
        check($sformatf("ct_done_idle_%0d", i), busy, 0);
      if (i == 3)  check("ct_r0_data", r0_rdata, 16'h1234);
      if (i == 7)  check("ct_r1_data", r1_rdata, 16'h00AB);
    end
    r0_req = 0; r1_req = 0;
    repeat (2) tick();

    // Asynchronous reset in the 2nd ACCESS cycle of an r0 write
    r0_req = 1; r0_addr = 16'h0010; r0_wdata = 16'h5555; r0_sz = 1; r0_we = 1;
    tick();
    check("ar_we_a1", mem_we, 1);
    tick();
    check("ar_we_a2", mem_we, 1);
    #2 reset = 1'b0;
    #1;
    check("ar_we_now",   mem_we,   0);
    check("ar_busy_now", busy,     0);
    check("ar_r0_rdata", r0_rdata, 0);
    r0_req = 0;
    r1_req = 1; r1_addr = 16'h0004; r1_sz = 1; r1_we = 0;
    #1 reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("ar_r0_ack_%0d", i), r0_ack, 0);
      check($sformatf("ar_r1_ack_%0d", i), r1_ack, (i == 3));
    end
    check("ar_r1_data", r1_rdata, 16'h1234);
    r1_req = 0;
    tick();

    // MEM_LAT=1 build: ack one cycle after grant, 3-cycle occupancy
    b_req = 1; b_addr = 16'h0022;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("l1_ack_%0d", i), b_r0_ack, (i == 2 || i == 5));
      if (i == 1) check("l1_busy_acc",  b_busy, 1);
      if (i == 3) check("l1_busy_idle", b_busy, 0);
      if (i == 2) check("l1_data", b_r0_rdata, 16'hA587);
    end
    check("l1_r1_ack",   b_r1_ack,    0);
    check("l1_r1_rdata", b_r1_rdata,  0);
    check("l1_we",       b_mem_we,    0);
    check("l1_sz",       b_mem_sz,    1);
    check("l1_wdata",    b_mem_wdata, 0);
    b_req = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Acks of the two requesters must never be high together.
  always @(negedge clk) begin
    if (reset && r0_ack && r1_ack)
      check("ack_exclusive", {r0_ack, r1_ack}, 2'b00);
  end

endmodule
